// File: rtl/jk_updown_counter.sv
// Purpose: debounced up/down modulo-MOD counter with JK excitation outputs and a wrap pulse for cascading.
// Latency: a button press steps count 3+DEBOUNCE edges after it is first sampled; load takes 1 edge.
// Backpressure: none; steps arriving while en is low or alongside a load are dropped, never queued.
//
// Ports:
//   clk       rising-edge clock for all state
//   reset     asynchronous active-low clear of every flop
//   en        step enable, sampled in the step cycle only
//   btn_up    raw pushbutton, increment
//   btn_down  raw pushbutton, decrement
//   load      synchronous parallel load strobe (beats any step)
//   load_val  value to load, saturated to MOD-1
//   count     registered count, 0..MOD-1
//   j_vec     J excitation for the transition taken at the next edge
//   k_vec     K excitation for the transition taken at the next edge
//   wrap      one-cycle pulse after MOD-1->0 (up) or 0->MOD-1 (down)
module jk_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MOD      = 10,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             wrap
);

  localparam int               CW       = $clog2(DEBOUNCE);
  localparam logic [CW-1:0]    DBC_LAST = CW'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] TOP      = WIDTH'(MOD - 1);

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]    raw;
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    db;
  logic [1:0]    db_d;
  logic [CW-1:0] dbc [2];

  logic             step_up;
  logic             step_dn;
  logic             load_over;
  logic [WIDTH-1:0] next;
  logic             wrap_next;

  assign raw = {btn_down, btn_up};

  // Synchroniser, debouncer and edge register for both buttons.
  // The debounce counter only runs while the synchronised level disagrees
  // with the accepted level; any agreeing cycle restarts the count, so a
  // level must differ for DEBOUNCE consecutive edges to be accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
      db     <= '0;
      db_d   <= '0;
      dbc[0] <= '0;
      dbc[1] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      db_d   <= db;
      for (int b = 0; b < 2; b++) begin
        if (sync_b[b] == db[b]) begin
          dbc[b] <= '0;
        end else if (dbc[b] == DBC_LAST) begin
          db[b]  <= sync_b[b];
          dbc[b] <= '0;
        end else begin
          dbc[b] <= dbc[b] + 1'b1;
        end
      end
    end
  end

  // Only accepted rising levels count; releases produce nothing.
  assign step_up = db[0] & ~db_d[0];
  assign step_dn = db[1] & ~db_d[1];

  // Compare one bit wider so MOD == 2**WIDTH never saturates.
  assign load_over = ({1'b0, load_val} > {1'b0, TOP});

  always_comb begin
    next      = count;
    wrap_next = 1'b0;
    if (load) begin
      next = load_over ? TOP : load_val;
    end else if (en && (step_up ^ step_dn)) begin
      // Simultaneous up and down cancel; only a lone step moves the count.
      if (step_up) begin
        if (count == TOP) begin
          next      = '0;
          wrap_next = 1'b1;
        end else begin
          next = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          next      = TOP;
          wrap_next = 1'b1;
        end else begin
          next = count - 1'b1;
        end
      end
    end
  end

  // J marks bits rising, K marks bits falling; they are never both set.
  assign j_vec = ~count & next;
  assign k_vec = count & ~next;

  // The count register behaves as a JK bank: J sets, K clears, else hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= (count & ~k_vec) | j_vec;
      wrap  <= wrap_next;
    end
  end

endmodule
